if_id_fifo: RTL

//  Decoupling buffer between the fetch stage (pc + instruction memory) and decode.
//  - Captures {PC, instruction} pairs from fetch; presents them in order to the ID stage.
//  - Valid/ready handshake on both sides; flushed on branch/jump redirect.
//  - Replaces the plain IF/ID register so that decode stalls do not gate the PC directly.

---
 rtl/if_id_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/if_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fifo
// Purpose  : In-order {PC, instruction} buffer between fetch and decode,
//            valid/ready on both sides, synchronous flush on redirect.
//            Optional macro FETCH_ADEL_EN adds per-entry fetch-address-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_fifo #(
    parameter int          DEPTH     = 2,
    parameter int          PTR_W     = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             F_Valid,
    output logic             F_Ready,
    input  logic [31:0]      F_PC,
    input  logic [31:0]      F_Instr,
    input  logic             Flush,
    output logic             D_Valid,
    input  logic             D_Ready,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_PC_plus8,
    output logic [31:0]      D_Instr,
    output logic [PTR_W:0]   Count
`ifdef FETCH_ADEL_EN
    ,
    output logic             D_AdEL
`endif
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign F_Ready = (count_q != C_FULL) & Reset;
    assign D_Valid = (count_q != '0);
    assign w_push  = F_Valid & F_Ready;
    assign w_pop   = D_Valid & D_Ready;
    assign Count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately not reset; only the occupancy is.
    always_ff @(posedge Clk) begin
        if (w_push && !Flush) begin
            pc_mem_q[wr_ptr_q]    <= F_PC;
            instr_mem_q[wr_ptr_q] <= F_Instr;
        end
    end

`ifdef FETCH_ADEL_EN
    logic flag_mem_q [DEPTH];
    logic w_adel;

    assign w_adel = (F_PC[1:0] != 2'b00) | (F_PC < 32'h0000_3000) | (F_PC > 32'h0000_6FFC);

    always_ff @(posedge Clk) begin
        if (w_push && !Flush) begin
            flag_mem_q[wr_ptr_q] <= w_adel;
        end
    end
`endif

    always_comb begin
        D_PC    = '0;
        D_Instr = NOP_INSTR;
`ifdef FETCH_ADEL_EN
        D_AdEL  = 1'b0;
`endif
        if (D_Valid) begin
            D_PC    = pc_mem_q[rd_ptr_q];
            D_Instr = instr_mem_q[rd_ptr_q];
`ifdef FETCH_ADEL_EN
            // A faulting fetch must never reach decode as a real instruction.
            D_AdEL  = flag_mem_q[rd_ptr_q];
            if (flag_mem_q[rd_ptr_q]) begin
                D_Instr = NOP_INSTR;
            end
`endif
        end
    end

    assign D_PC_plus8 = D_PC + 32'd8;

endmodule
`default_nettype wire
